// File: rtl/vga_timing_gen.sv
// Raster timing generator: half-rate pixel strobe, x/y counters, cell coordinates and sof.
// Define VGA_GEN_TICK_EN to build the frame counter driving gen_tick; otherwise gen_tick is 0.
module vga_timing_gen #(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned CELL_SHIFT = 4,
    parameter int unsigned GEN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       pix_en,
    output logic [9:0] counter_x,
    output logic [9:0] counter_y,
    output logic       in_display,
    output logic [5:0] cell_col,
    output logic [4:0] cell_row,
    output logic       sof,
    output logic       gen_tick
);

    logic       pix_en_q;
    logic [9:0] cx_q, cx_d;
    logic [9:0] cy_q, cy_d;
    logic       x_wrap;
    logic       y_last;
    logic       sof_q;

    assign x_wrap = pix_en_q && (cx_q == 10'(H_TOTAL - 1));
    assign y_last = (cy_q == 10'(V_TOTAL - 1));

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (pix_en_q) begin
            if (x_wrap) begin
                cx_d = '0;
                cy_d = y_last ? '0 : cy_q + 10'd1;
            end else begin
                cx_d = cx_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en_q <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            sof_q    <= 1'b0;
        end else begin
            pix_en_q <= ~pix_en_q;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            // Only a genuine wrap to (0,0) raises sof, never reset itself.
            sof_q    <= x_wrap && y_last;
        end
    end

    assign pix_en     = pix_en_q;
    assign counter_x  = cx_q;
    assign counter_y  = cy_q;
    assign sof        = sof_q;
    assign in_display = (cx_q < 10'(H_ACTIVE)) && (cy_q < 10'(V_ACTIVE));
    assign cell_col   = 6'(cx_q >> CELL_SHIFT);
    assign cell_row   = 5'(cy_q >> CELL_SHIFT);

`ifdef VGA_GEN_TICK_EN
    logic [7:0] frame_q;
    logic       gen_tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q    <= '0;
            gen_tick_q <= 1'b0;
        end else begin
            gen_tick_q <= 1'b0;
            if (sof_q && run) begin
                if (frame_q == 8'(GEN_FRAMES - 1)) begin
                    frame_q    <= '0;
                    gen_tick_q <= 1'b1;
                end else begin
                    frame_q <= frame_q + 8'd1;
                end
            end
        end
    end

    assign gen_tick = gen_tick_q;
`else
    logic unused_run;
    assign unused_run = run;
    assign gen_tick   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster; expected values come from elapsed-clock arithmetic.
module tb_vga_timing_gen;

    localparam int unsigned HT = 40;
    localparam int unsigned VT = 20;
    localparam int unsigned HA = 32;
    localparam int unsigned VA = 15;
    localparam int unsigned CS = 3;
    localparam int unsigned GF = 2;
    localparam int FRAME_CLK = 2 * HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       pix_en;
    logic [9:0] counter_x;
    logic [9:0] counter_y;
    logic       in_display;
    logic [5:0] cell_col;
    logic [4:0] cell_row;
    logic       sof;
    logic       gen_tick;

    vga_timing_gen #(
        .H_TOTAL   (HT),
        .V_TOTAL   (VT),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA),
        .CELL_SHIFT(CS),
        .GEN_FRAMES(GF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .pix_en    (pix_en),
        .counter_x (counter_x),
        .counter_y (counter_y),
        .in_display(in_display),
        .cell_col  (cell_col),
        .cell_row  (cell_row),
        .sof       (sof),
        .gen_tick  (gen_tick)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    // Model: k = clk edges since reset release; pixel index = k/2.
    int   k = 0;
    int   runs = 0;
    logic gen_exp = 1'b0;
    int   last_sof = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit sof_at(input int kk);
        return kk > 0 && (kk % 2) == 0 && ((kk / 2) % (HT * VT)) == 0;
    endfunction

    function automatic int mx();
        return (k / 2) % HT;
    endfunction

    function automatic int my();
        return ((k / 2) / HT) % VT;
    endfunction

    task automatic check_all();
        int  x, y;
        bit  ind;
        x   = mx();
        y   = my();
        ind = (x < HA) && (y < VA);
        chk("pix_en", 32'(pix_en), 32'(k % 2));
        chk("counter_x", 32'(counter_x), 32'(x));
        chk("counter_y", 32'(counter_y), 32'(y));
        chk("in_display", 32'(in_display), 32'(ind));
        if (ind) begin
            chk("cell_col", 32'(cell_col), 32'((x >> CS) & 63));
            chk("cell_row", 32'(cell_row), 32'((y >> CS) & 31));
        end
        chk("sof", 32'(sof), 32'(sof_at(k)));
        chk("gen_tick", 32'(gen_tick), 32'(gen_exp));
        if (sof === 1'b1) begin
            if (last_sof >= 0) chk("sof_period", 32'(k - last_sof), 32'(FRAME_CLK));
            else chk("first_sof_delay", 32'(k), 32'(FRAME_CLK));
            last_sof = k;
        end
    endtask

    // One clk: advance model on posedge using sampled run, compare on negedge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            if (sof_at(k) && run) begin
                runs++;
                gen_exp = ((runs % GF) == 0);
            end else begin
                gen_exp = 1'b0;
            end
`ifndef VGA_GEN_TICK_EN
            gen_exp = 1'b0;
`endif
            k++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        k        = 0;
        runs     = 0;
        gen_exp  = 1'b0;
        last_sof = -1;
        #1;
        check_all();
        cycles(n);
        rst = 1'b0;
    endtask

    task automatic wait_xy(input int x, input int y);
        bit found = 1'b0;
        for (int i = 0; i < FRAME_CLK + 4 && !found; i++) begin
            cycle();
            if (mx() == x && my() == y) found = 1'b1;
        end
        chk("wait_xy_timeout", 32'(found), 32'd1);
    endtask

    task automatic wait_sof();
        bit found = 1'b0;
        for (int i = 0; i < FRAME_CLK + 4 && !found; i++) begin
            cycle();
            if (sof_at(k)) found = 1'b1;
        end
        chk("wait_sof_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        // Reset asserted before any clock edge, held 5 clk.
        do_reset(5);

        // Release: pix_en 1 with counters held, then counter_x moves to 1.
        cycle();
        chk("rel_pix1", 32'(pix_en), 32'd1);
        chk("rel_x_held", 32'(counter_x), 32'd0);
        cycle();
        chk("rel_pix0", 32'(pix_en), 32'd0);
        chk("rel_x1", 32'(counter_x), 32'd1);
        cycle();
        chk("rel_pix1b", 32'(pix_en), 32'd1);

        // Line wrap: last pixel of line 0, then (0,1).
        wait_xy(HT - 1, 0);
        chk("line_end_x", 32'(counter_x), 32'(HT - 1));
        wait_xy(0, 1);
        chk("line_wrap_x", 32'(counter_x), 32'd0);
        chk("line_wrap_y", 32'(counter_y), 32'd1);

        // Display-area corners.
        wait_xy(HA - 1, VA - 1);
        chk("corner_in", 32'(in_display), 32'd1);
        chk("corner_col", 32'(cell_col), 32'((HA - 1) >> CS));
        chk("corner_row", 32'(cell_row), 32'((VA - 1) >> CS));
        wait_xy(HA, VA - 1);
        chk("right_out", 32'(in_display), 32'd0);
        wait_xy(HA - 1, VA);
        chk("below_out", 32'(in_display), 32'd0);

        // Free run with run=1, then run=0 for 3 frames, then resume.
        run = 1'b1;
        cycles(4 * FRAME_CLK);
        run = 1'b0;
        cycles(3 * FRAME_CLK);
        run = 1'b1;
        cycles(3 * FRAME_CLK);

        // Random run value applied exactly in sof cycles.
        for (int i = 0; i < 4; i++) begin
            wait_sof();
            run = 1'($urandom_range(0, 1));
        end

        // Random run toggling.
        for (int i = 0; i < 4 * FRAME_CLK; i++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            cycle();
        end

        // Reset mid-frame for 3 clk, then two frames of normal counting.
        run = 1'b1;
        cycles($urandom_range(100, FRAME_CLK - 100));
        do_reset(3);
        cycles(2 * FRAME_CLK + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
